// File: rtl/mgt_01_int_writeback_pkg.sv
// Shared types for the integer writeback path: register names, data bus,
// writeback source tags and the per-source request payload.
package mgt_01_int_writeback_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned DEF_NUM_REGS      = 32;
  localparam int unsigned DEF_STARVE_LIMIT  = 4;

  typedef logic [XLEN-1:0] data_bus_t;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU,
    WB_MDU
  } wb_src_e;

  typedef struct packed {
    logic        valid;
    i_register_e rd;
    data_bus_t   data;
  } wb_req_t;

endpackage

// File: rtl/mgt_01_scoreboard.sv
// Busy-register bitmap: issue sets, writeback clears, a same-edge set wins.
module mgt_01_scoreboard
  import mgt_01_int_writeback_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                set_valid_i,
  input  i_register_e         set_rd_i,
  input  logic                clr_valid_i,
  input  i_register_e         clr_rd_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid_i) set_mask[set_rd_i] = 1'b1;
    if (clr_valid_i) clr_mask[clr_rd_i] = 1'b1;
    // X0 never holds a pending write.
    busy_d = ((busy_o & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_o <= '0;
    end else begin
      busy_o <= busy_d;
    end
  end

endmodule

// File: rtl/mgt_01_int_writeback.sv
// Integer register file write-port master: arbitrates ALU/LSU/MDU results
// with MDU anti-starvation, registers the write and tracks busy registers.
module mgt_01_int_writeback
  import mgt_01_int_writeback_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned NUM_REGS     = DEF_NUM_REGS
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                issue_valid_i,
  input  i_register_e         issue_rd_i,
  input  logic                alu_valid_i,
  input  i_register_e         alu_rd_i,
  input  data_bus_t           alu_data_i,
  input  logic                lsu_valid_i,
  output logic                lsu_ready_o,
  input  i_register_e         lsu_rd_i,
  input  data_bus_t           lsu_data_i,
  input  logic                mdu_valid_i,
  output logic                mdu_ready_o,
  input  i_register_e         mdu_rd_i,
  input  data_bus_t           mdu_data_i,
  output logic                we_o,
  output i_register_e         w_iaddr_o,
  output data_bus_t           wr_idata_o,
  output logic [NUM_REGS-1:0] busy_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t              alu_req;
  wb_req_t              lsu_req;
  wb_req_t              mdu_req;
  wb_req_t              win_req;
  wb_src_e              win_src;
  logic [STARVE_W-1:0]  starve_cnt;
  logic [STARVE_W-1:0]  starve_cnt_d;
  logic                 mdu_promoted;

  assign alu_req = wb_req_t'{valid: alu_valid_i, rd: alu_rd_i, data: alu_data_i};
  assign lsu_req = wb_req_t'{valid: lsu_valid_i, rd: lsu_rd_i, data: lsu_data_i};
  assign mdu_req = wb_req_t'{valid: mdu_valid_i, rd: mdu_rd_i, data: mdu_data_i};

  assign mdu_promoted = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

  // Readies are forced low while reset is asserted so nothing handshakes.
  assign lsu_ready_o = rst_n_i && !alu_valid_i && (!mdu_promoted || !mdu_valid_i);
  assign mdu_ready_o = rst_n_i && !alu_valid_i && (mdu_promoted || !lsu_valid_i);

  always_comb begin
    win_src = WB_NONE;
    if (alu_req.valid) begin
      win_src = WB_ALU;
    end else if (lsu_req.valid && lsu_ready_o) begin
      win_src = WB_LSU;
    end else if (mdu_req.valid && mdu_ready_o) begin
      win_src = WB_MDU;
    end
  end

  always_comb begin
    win_req = '0;
    case (win_src)
      WB_ALU:  win_req = alu_req;
      WB_LSU:  win_req = lsu_req;
      WB_MDU:  win_req = mdu_req;
      default: win_req = '0;
    endcase
  end

  // Count consecutive refusals of a waiting MDU result, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt;
    if (!mdu_valid_i || mdu_ready_o) begin
      starve_cnt_d = '0;
    end else if (starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_d;
    end
  end

  // Write port; an X0 destination still updates address/data but never writes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_o       <= 1'b0;
      w_iaddr_o  <= X0;
      wr_idata_o <= '0;
    end else begin
      we_o <= win_req.valid && (win_req.rd != X0);
      if (win_req.valid) begin
        w_iaddr_o  <= win_req.rd;
        wr_idata_o <= win_req.data;
      end
    end
  end

  mgt_01_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .set_valid_i (issue_valid_i),
    .set_rd_i    (issue_rd_i),
    .clr_valid_i (win_req.valid),
    .clr_rd_i    (win_req.rd),
    .busy_o      (busy_o)
  );

endmodule

// File: tb/tb_mgt_01_int_writeback.sv
// Directed and random stimulus for mgt_01_int_writeback against a
// priority-list reference model of the writeback arbiter and scoreboard.
module tb_mgt_01_int_writeback;
  import mgt_01_int_writeback_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  i_register_e issue_rd;
  logic        alu_valid, lsu_valid, mdu_valid;
  i_register_e alu_rd, lsu_rd, mdu_rd;
  data_bus_t   alu_data, lsu_data, mdu_data;
  logic        lsu_ready, mdu_ready;
  logic        we;
  i_register_e w_iaddr;
  data_bus_t   wr_idata;
  logic [31:0] busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_starve;
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  mgt_01_int_writeback dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .alu_valid_i   (alu_valid),
    .alu_rd_i      (alu_rd),
    .alu_data_i    (alu_data),
    .lsu_valid_i   (lsu_valid),
    .lsu_ready_o   (lsu_ready),
    .lsu_rd_i      (lsu_rd),
    .lsu_data_i    (lsu_data),
    .mdu_valid_i   (mdu_valid),
    .mdu_ready_o   (mdu_ready),
    .mdu_rd_i      (mdu_rd),
    .mdu_data_i    (mdu_data),
    .we_o          (we),
    .w_iaddr_o     (w_iaddr),
    .wr_idata_o    (wr_idata),
    .busy_o        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_busy   = '0;
    m_we     = 1'b0;
    m_addr   = 5'd0;
    m_data   = '0;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = X0;
    alu_valid = 1'b0; alu_rd = X0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = X0; lsu_data = '0;
    mdu_valid = 1'b0; mdu_rd = X0; mdu_data = '0;
  endtask

  // One clock: check readies mid-cycle, advance model at the edge, check outputs.
  task automatic cycle(input string tag);
    int ord[3];
    bit v[3];
    bit rdy[3];
    int win;
    logic [4:0]  rds[3];
    logic [31:0] dat[3];
    v = '{alu_valid, lsu_valid, mdu_valid};
    rds = '{5'(alu_rd), 5'(lsu_rd), 5'(mdu_rd)};
    dat = '{alu_data, lsu_data, mdu_data};
    if (m_starve >= LIMIT) ord = '{0, 2, 1};
    else                   ord = '{0, 1, 2};
    // A source is ready when nobody ahead of it in the order is requesting.
    for (int s = 0; s < 3; s++) begin
      bit blocked;
      blocked = 1'b0;
      rdy[s] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (ord[k] == s) begin
          rdy[s] = !blocked;
          break;
        end
        blocked = blocked | v[ord[k]];
      end
    end
    win = -1;
    for (int k = 0; k < 3; k++)
      if (v[ord[k]] && win < 0) win = ord[k];
    #2;
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(rdy[1]));
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(rdy[2]));
    @(posedge clk);
    if (v[2] && win != 2) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else                  m_starve = 0;
    if (win >= 0) begin
      m_we   = (rds[win] != 5'd0);
      m_addr = rds[win];
      m_data = dat[win];
      m_busy[rds[win]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid) m_busy[5'(issue_rd)] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
    chk({tag, ".we"},   32'(we),       32'(m_we));
    chk({tag, ".addr"}, 32'(w_iaddr),  32'(m_addr));
    chk({tag, ".data"}, wr_idata,      m_data);
    chk({tag, ".busy"}, busy,          m_busy);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    lsu_valid = 1'b1;
    #1;
    chk("reset.we",        32'(we),        32'd0);
    chk("reset.addr",      32'(w_iaddr),   32'd0);
    chk("reset.data",      wr_idata,       32'd0);
    chk("reset.busy",      busy,           32'd0);
    chk("reset.lsu_ready", 32'(lsu_ready), 32'd0);
    chk("reset.mdu_ready", 32'(mdu_ready), 32'd0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU write with its scoreboard entry
    issue_valid = 1'b1; issue_rd = X1;
    cycle("alu_issue");
    idle(); alu_valid = 1'b1; alu_rd = X1; alu_data = 32'd1000;
    cycle("alu_write");
    chk("alu_write.const_addr", 32'(w_iaddr), 32'd1);
    chk("alu_write.const_data", wr_idata, 32'd1000);
    idle();
    cycle("alu_idle");

    // X0 destination: handshake but no write
    alu_valid = 1'b1; alu_rd = X0; alu_data = 32'd500;
    cycle("x0_write");
    chk("x0_write.const_we", 32'(we), 32'd0);
    idle();
    cycle("x0_idle");

    // Three-way conflict drains in priority order
    alu_valid = 1'b1; alu_rd = X2; alu_data = 32'd7;
    lsu_valid = 1'b1; lsu_rd = X3; lsu_data = 32'd8;
    mdu_valid = 1'b1; mdu_rd = X4; mdu_data = 32'd9;
    cycle("conflict_alu");
    alu_valid = 1'b0;
    cycle("conflict_lsu");
    lsu_valid = 1'b0;
    cycle("conflict_mdu");
    chk("conflict_mdu.const_addr", 32'(w_iaddr), 32'd4);
    idle();
    cycle("conflict_idle");

    // Starvation: MDU promoted after four refusals
    lsu_valid = 1'b1; lsu_rd = X10; lsu_data = 32'hA0;
    mdu_valid = 1'b1; mdu_rd = X11; mdu_data = 32'hB0;
    for (int i = 0; i < 4; i++) cycle("starve_refused");
    cycle("starve_promoted");
    chk("starve_promoted.const_addr", 32'(w_iaddr), 32'd11);
    mdu_valid = 1'b0;
    cycle("starve_lsu_after");
    mdu_valid = 1'b1; mdu_rd = X12; mdu_data = 32'hB1;
    cycle("starve_cleared");
    idle();
    cycle("starve_idle");

    // Scoreboard set/clear collision on X5
    issue_valid = 1'b1; issue_rd = X5;
    cycle("sb_issue");
    lsu_valid = 1'b1; lsu_rd = X5; lsu_data = 32'h55;
    cycle("sb_collide");
    chk("sb_collide.const_busy5", 32'(busy[5]), 32'd1);
    idle(); alu_valid = 1'b1; alu_rd = X5; alu_data = 32'h66;
    cycle("sb_clear");
    chk("sb_clear.const_busy5", 32'(busy[5]), 32'd0);
    idle();

    // Async reset while a write is on the port
    issue_valid = 1'b1; issue_rd = X9;
    cycle("rst_issue");
    idle(); alu_valid = 1'b1; alu_rd = X7; alu_data = 32'h77;
    cycle("rst_write");
    idle(); lsu_valid = 1'b1; lsu_rd = X8;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid.we",        32'(we),        32'd0);
    chk("rst_mid.busy",      busy,           32'd0);
    chk("rst_mid.lsu_ready", 32'(lsu_ready), 32'd0);
    chk("rst_mid.addr",      32'(w_iaddr),   32'd0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    cycle("rst_after");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = i_register_e'(5'($urandom_range(0, 31)));
      alu_valid   = ($urandom_range(0, 3) == 0);
      alu_rd      = i_register_e'(5'($urandom_range(0, 31)));
      alu_data    = $urandom;
      lsu_valid   = ($urandom_range(0, 1) == 0);
      lsu_rd      = i_register_e'(5'($urandom_range(0, 31)));
      lsu_data    = $urandom;
      mdu_valid   = ($urandom_range(0, 2) != 0);
      mdu_rd      = i_register_e'(5'($urandom_range(0, 31)));
      mdu_data    = $urandom;
      cycle("random");
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
